sort4_stream: RTL

- Sequential wrapper that gathers a serial stream of 4-bit samples into frames of four.
- Sorts each frame with the team's existing combinational sort4 network and re-emits the sorted frame serially.
- Sits between a nibble producer, such as an ADC/UART front end, and any serial consumer; valid/ready handshake on both sides.
- One frame in flight at a time; no overlap between fill and drain.

---
 rtl/sort4_stream_pkg.sv | 14 +
 rtl/sort4.sv | 30 +++
 rtl/sort4_stream.sv | 93 +++++++++
 3 files changed

// File: rtl/sort4_stream_pkg.sv
// Shared constants and state encoding for the sort4 streaming wrapper.
package sort4_stream_pkg;

  localparam int unsigned DW        = 4;
  localparam int unsigned FRAME_LEN = 4;

  // 2'd3 is unused and recovers to FILL.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sort4.sv
// Combinational 4-input sorting network; ra..rd ascending (ra smallest).
module sort4
  import sort4_stream_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] ra,
  output logic [DW-1:0] rb,
  output logic [DW-1:0] rc,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] l1, h1, l2, h2, m1, m2;

  always_comb begin
    l1 = (a < b) ? a : b;
    h1 = (a < b) ? b : a;
    l2 = (c < d) ? c : d;
    h2 = (c < d) ? d : c;
    ra = (l1 < l2) ? l1 : l2;
    m1 = (l1 < l2) ? l2 : l1;
    rd = (h1 < h2) ? h2 : h1;
    m2 = (h1 < h2) ? h1 : h2;
    rb = (m1 < m2) ? m1 : m2;
    rc = (m1 < m2) ? m2 : m1;
  end

endmodule

// File: rtl/sort4_stream.sv
// Gathers four serial nibbles, sorts them through sort4 and re-emits the
// sorted frame serially; one frame in flight at a time.
module sort4_stream
  import sort4_stream_pkg::*;
#(
  parameter bit          DESCEND = 1'b0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  state_t        state, nstate;
  logic [1:0]    idx, didx;
  logic [DW-1:0] cap [FRAME_LEN];
  logic [DW-1:0] res [FRAME_LEN];
  logic [DW-1:0] ra, rb, rc, rd;
  logic          in_xfer, out_xfer;

  sort4 u_sort4 (
    .a (cap[0]),
    .b (cap[1]),
    .c (cap[2]),
    .d (cap[3]),
    .ra(ra),
    .rb(rb),
    .rc(rc),
    .rd(rd)
  );

  assign in_xfer  = in_valid  && (state == FILL);
  assign out_xfer = out_ready && (state == DRAIN);

  always_comb begin
    nstate = FILL;
    case (state)
      FILL:    nstate = (in_xfer && idx == 2'(FRAME_LEN - 1)) ? SORT : FILL;
      SORT:    nstate = DRAIN;
      DRAIN:   nstate = (out_xfer && didx == 2'(FRAME_LEN - 1)) ? FILL : DRAIN;
      default: nstate = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= nstate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      didx      <= '0;
      frame_cnt <= '0;
      for (int unsigned i = 0; i < FRAME_LEN; i++) begin
        cap[i] <= '0;
        res[i] <= '0;
      end
    end else begin
      // Indices are 2 bits wide, so the step after 3 lands back on 0.
      if (in_xfer) begin
        cap[idx] <= in_data;
        idx      <= idx + 2'd1;
      end
      if (state == SORT) begin
        if (DESCEND) begin
          res[0] <= rd; res[1] <= rc; res[2] <= rb; res[3] <= ra;
        end else begin
          res[0] <= ra; res[1] <= rb; res[2] <= rc; res[3] <= rd;
        end
      end
      if (out_xfer) begin
        didx <= didx + 2'd1;
        if (didx == 2'(FRAME_LEN - 1)) frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign out_last  = (state == DRAIN) && (didx == 2'(FRAME_LEN - 1));
  assign busy      = (state == SORT) || (state == DRAIN);
  assign out_data  = (state == DRAIN) ? res[didx] : '0;

endmodule
